// File: rtl/uart_hamming_transmitter.sv
// UART transmitter for 7-bit Hamming(7,4) codewords: one-entry holding buffer,
// start/7 data/stop framing at CLKS_PER_BIT enabled clocks per bit.
module uart_hamming_transmitter #(
  parameter int CLKS_PER_BIT = 8,
  parameter bit ENCODE       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic [1:0] state_out,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  state_t           state, state_nx;
  logic             tx_nx;
  logic [6:0]       hold, hold_nx;
  logic             hold_full, hold_full_nx;
  logic [6:0]       shifter, shifter_nx;
  logic [CNT_W-1:0] sample_cnt, sample_cnt_nx;
  logic [2:0]       bit_cnt, bit_cnt_nx;

  logic [6:0] encoded;
  logic [6:0] codeword;
  logic       bit_end;
  logic       load;

  assign encoded = {data_in[3], data_in[2], data_in[1],
                    data_in[1] ^ data_in[2] ^ data_in[3],
                    data_in[0],
                    data_in[0] ^ data_in[2] ^ data_in[3],
                    data_in[0] ^ data_in[1] ^ data_in[3]};
  assign codeword = ENCODE ? encoded : data_in;

  assign ready_out = ~hold_full;
  assign busy      = (state != IDLE) | hold_full;
  assign state_out = state;
  assign bit_end   = (sample_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      hold       <= '0;
      hold_full  <= 1'b0;
      shifter    <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else if (ena) begin
      state      <= state_nx;
      tx         <= tx_nx;
      hold       <= hold_nx;
      hold_full  <= hold_full_nx;
      shifter    <= shifter_nx;
      sample_cnt <= sample_cnt_nx;
      bit_cnt    <= bit_cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    tx_nx         = tx;
    hold_nx       = hold;
    hold_full_nx  = hold_full;
    shifter_nx    = shifter;
    sample_cnt_nx = bit_end ? '0 : sample_cnt + 1'b1;
    bit_cnt_nx    = bit_cnt;
    load          = 1'b0;

    case (state)
      IDLE: begin
        sample_cnt_nx = '0;
        load          = hold_full;
      end
      START: begin
        if (bit_end) begin
          state_nx   = DATA;
          tx_nx      = shifter[0];
          bit_cnt_nx = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd6) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            shifter_nx = shifter >> 1;
            tx_nx      = shifter[1];
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          load     = hold_full;
        end
      end
      default: begin
        state_nx      = IDLE;
        tx_nx         = 1'b1;
        sample_cnt_nx = '0;
      end
    endcase

    // Load from the holding buffer chains frames with no idle gap after the stop bit.
    if (load) begin
      shifter_nx    = hold;
      hold_full_nx  = 1'b0;
      state_nx      = START;
      tx_nx         = 1'b0;
      sample_cnt_nx = '0;
    end

    if (valid_in && ready_out) begin
      hold_nx      = codeword;
      hold_full_nx = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_hamming_transmitter.sv
// Self-checking bench: encoded and raw transmitters driven in lockstep, every
// enabled cycle compared against a frame model derived from the Hamming rules.
module tb_uart_hamming_transmitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       valid_in = 1'b0;
  logic [6:0] data_in = '0;
  logic       ready1, tx1, busy1, ready0, tx0, busy0;
  logic [1:0] st1, st0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_hamming_transmitter #(.CLKS_PER_BIT(8), .ENCODE(1'b1)) u_enc (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready1), .tx(tx1), .state_out(st1), .busy(busy1));

  uart_hamming_transmitter #(.CLKS_PER_BIT(8), .ENCODE(1'b0)) u_raw (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready0), .tx(tx0), .state_out(st0), .busy(busy0));

  // Classical Hamming layout: parity at power-of-two positions 1,2,4.
  function automatic logic [6:0] ham(input logic [3:0] d);
    logic [7:1] pos;
    logic       par;
    int         k;
    pos = '0;
    k = 0;
    for (int p = 1; p <= 7; p++)
      if ((p & (p - 1)) != 0) begin
        pos[p] = d[k];
        k++;
      end
    for (int j = 0; j < 3; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 7; p++)
        if ((p & (1 << j)) != 0) par ^= pos[p];
      pos[1 << j] = par;
    end
    return pos[7:1];
  endfunction

  function automatic logic frame_bit(input logic [6:0] cw, input int e);
    int idx;
    idx = e / 8;
    if (idx == 0) return 1'b0;
    if (idx >= 8) return 1'b1;
    return cw[idx-1];
  endfunction

  function automatic logic [1:0] frame_state(input int e);
    if (e < 8) return 2'd1;
    if (e < 64) return 2'd2;
    return 2'd3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx1"}, tx1, 1);
    chk({tag, "_tx0"}, tx0, 1);
    chk({tag, "_st1"}, st1, 0);
    chk({tag, "_st0"}, st0, 0);
    chk({tag, "_rdy1"}, ready1, 1);
    chk({tag, "_rdy0"}, ready0, 1);
    chk({tag, "_busy1"}, busy1, 0);
    chk({tag, "_busy0"}, busy0, 0);
  endtask

  task automatic idle_cycle();
    ena = 1'b1;
    @(negedge clk);
    chk_idle("idle");
  endtask

  // Present a word at E0; optionally keep valid high with a follow-up word.
  task automatic start(input logic [6:0] d, input bit keep, input logic [6:0] next_d);
    ena = 1'b1;
    valid_in = 1'b1;
    data_in = d;
    @(negedge clk);
    chk("accept_rdy1", ready1, 0);
    chk("accept_rdy0", ready0, 0);
    chk("accept_busy1", busy1, 1);
    chk("accept_st1", st1, 0);
    if (keep) data_in = next_d;
    else valid_in = 1'b0;
  endtask

  // One frame, e = enabled edges after E1. gap disabled cycles precede each enabled edge.
  task automatic run_frame(input logic [6:0] cw1, input logic [6:0] cw0, input int gap,
                           input int push_e, input logic [6:0] push_d,
                           input logic [6:0] junk_d, input int abort_e);
    for (int e = 0; e < 72; e++) begin
      for (int g = 0; g < gap; g++) begin
        ena = 1'b0;
        @(negedge clk);
        chk("hold_tx1", tx1, (e == 0) ? 1'b1 : frame_bit(cw1, e - 1));
        chk("hold_tx0", tx0, (e == 0) ? 1'b1 : frame_bit(cw0, e - 1));
      end
      ena = 1'b1;
      @(negedge clk);
      chk("tx1", tx1, frame_bit(cw1, e));
      chk("tx0", tx0, frame_bit(cw0, e));
      chk("st1", st1, frame_state(e));
      chk("st0", st0, frame_state(e));
      chk("rdy1", ready1, (push_e >= 0 && e > push_e) ? 1'b0 : 1'b1);
      chk("rdy0", ready0, (push_e >= 0 && e > push_e) ? 1'b0 : 1'b1);
      if (e == abort_e) begin
        #2 rst_n = 1'b0;
        #1 chk_idle("async_rst");
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (push_e >= 0) begin
        if (e == push_e) begin
          valid_in = 1'b1;
          data_in = push_d;
        end else if (e == push_e + 1) begin
          data_in = junk_d;
        end else if (e == push_e + 4) begin
          valid_in = 1'b0;
        end
      end
    end
  endtask

  logic [3:0] nib [16];
  logic [6:0] w [16];
  logic [3:0] t;
  int         r;

  initial begin
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    idle_cycle();

    // single encoded frame, 4'hB -> codeword 7'h55
    start(7'h0B, 1'b0, 7'h00);
    run_frame(ham(4'hB), 7'h0B, 0, -1, 7'h00, 7'h00, -1);
    idle_cycle();

    // back-to-back with valid held: 0 then F, stop not shortened
    start(7'h00, 1'b1, 7'h7F);
    run_frame(ham(4'h0), 7'h00, 0, 0, 7'h7F, 7'h7F, -1);
    run_frame(ham(4'hF), 7'h7F, 0, -1, 7'h00, 7'h00, -1);
    idle_cycle();
    idle_cycle();

    // ena asserted every other cycle stretches each bit to 16 clocks
    start(7'h35, 1'b0, 7'h00);
    run_frame(ham(4'h5), 7'h35, 1, -1, 7'h00, 7'h00, -1);
    idle_cycle();

    // raw 7'h2A, second word buffered, third word while full must be ignored
    start(7'h2A, 1'b0, 7'h00);
    run_frame(ham(4'hA), 7'h2A, 0, 2, 7'h13, 7'h66, -1);
    run_frame(ham(4'h3), 7'h13, 0, -1, 7'h00, 7'h00, -1);
    idle_cycle();

    // async reset during data bit 3 discards the frame and the buffered word
    start(7'h4C, 1'b0, 7'h00);
    run_frame(ham(4'hC), 7'h4C, 0, 0, 7'h51, 7'h51, 35);
    idle_cycle();
    idle_cycle();

    // all 16 nibbles in random order, random upper bits, chained frames
    for (int i = 0; i < 16; i++) nib[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      r = int'($urandom_range(0, i));
      t = nib[i];
      nib[i] = nib[r];
      nib[r] = t;
    end
    for (int i = 0; i < 16; i++) w[i] = {3'($urandom), nib[i]};
    start(w[0], 1'b1, w[1]);
    for (int i = 0; i < 16; i++) begin
      if (i < 15)
        run_frame(ham(w[i][3:0]), w[i], int'($urandom_range(0, 1)), 0, w[i+1], w[i+1], -1);
      else
        run_frame(ham(w[i][3:0]), w[i], 0, -1, 7'h00, 7'h00, -1);
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
